// File: rtl/crop_window_filter.sv
// Streaming crop of an IN_ROWS x IN_COLS raster to a per-frame box, with a
// double-buffered box register and a 2-entry registered output skid buffer.
module crop_window_filter #(
  parameter int PIXEL_BIT_WIDTH  = 12,
  parameter int IN_ROWS          = 40,
  parameter int IN_COLS          = 40,
  parameter int IMG_ROW_BITWIDTH = 10,
  parameter int IMG_COL_BITWIDTH = 10
) (
  input  logic                                               clk,
  input  logic                                               reset_n,
  input  logic [PIXEL_BIT_WIDTH-1:0]                         pixel_in_TDATA,
  input  logic                                               pixel_in_TVALID,
  input  logic                                               pixel_in_TUSER,
  output logic                                               pixel_in_TREADY,
  input  logic [2*(IMG_ROW_BITWIDTH+IMG_COL_BITWIDTH)-1:0]   crop_box_TDATA,
  input  logic                                               crop_box_TVALID,
  output logic                                               crop_box_TREADY,
  output logic [PIXEL_BIT_WIDTH-1:0]                         pixel_out_TDATA,
  output logic                                               pixel_out_TVALID,
  output logic                                               pixel_out_TUSER,
  output logic                                               pixel_out_TLAST,
  input  logic                                               pixel_out_TREADY,
  output logic                                               sof_error
);

  localparam int RB    = IMG_ROW_BITWIDTH;
  localparam int CB    = IMG_COL_BITWIDTH;
  localparam int BOX_W = 2 * (RB + CB);
  localparam logic [CB:0]   COLS_EXT = (CB+1)'(IN_COLS);
  localparam logic [RB:0]   ROWS_EXT = (RB+1)'(IN_ROWS);
  localparam logic [CB-1:0] LAST_X   = CB'(IN_COLS - 1);
  localparam logic [RB-1:0] LAST_Y   = RB'(IN_ROWS - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state;

  logic [BOX_W-1:0] shadow;
  logic             shadow_valid;
  logic [CB-1:0]    act_x1, act_xe;
  logic [RB-1:0]    act_y1, act_ye;
  logic             act_empty;
  logic [CB-1:0]    x;
  logic [RB-1:0]    y;

  logic [CB-1:0]    sh_x1, sh_w, sh_xe;
  logic [RB-1:0]    sh_y1, sh_h, sh_ye;
  logic [CB:0]      sh_xlim;
  logic [RB:0]      sh_ylim;
  logic             sh_empty;

  logic             box_fire, in_fire, resync, at_end, in_win, push, pop;
  logic             win_user, win_last;
  logic [CB-1:0]    ex, nx;
  logic [RB-1:0]    ey, ny;

  logic                       spare_valid;
  logic [PIXEL_BIT_WIDTH-1:0] spare_data;
  logic                       spare_user, spare_last;

  assign crop_box_TREADY = ~shadow_valid;
  assign pixel_in_TREADY = (state == ACTIVE) && !spare_valid;

  // Window end points are resolved once, when the shadow box is promoted.
  always_comb begin
    sh_x1   = shadow[CB-1:0];
    sh_y1   = shadow[CB +: RB];
    sh_w    = shadow[CB+RB +: CB];
    sh_h    = shadow[2*CB+RB +: RB];
    sh_xlim = {1'b0, sh_x1} + {1'b0, sh_w};
    sh_ylim = {1'b0, sh_y1} + {1'b0, sh_h};
    if (sh_xlim > COLS_EXT) sh_xlim = COLS_EXT;
    if (sh_ylim > ROWS_EXT) sh_ylim = ROWS_EXT;
    sh_xe    = CB'(sh_xlim - (CB+1)'(1));
    sh_ye    = RB'(sh_ylim - (RB+1)'(1));
    sh_empty = (sh_w == '0) || (sh_h == '0) ||
               ({1'b0, sh_x1} >= COLS_EXT) || ({1'b0, sh_y1} >= ROWS_EXT);
  end

  always_comb begin
    box_fire = crop_box_TVALID && !shadow_valid;
    in_fire  = pixel_in_TVALID && pixel_in_TREADY;
    resync   = pixel_in_TUSER && ((x != '0) || (y != '0));
    ex       = resync ? '0 : x;
    ey       = resync ? '0 : y;
    at_end   = (ex == LAST_X) && (ey == LAST_Y);
    nx       = (ex == LAST_X) ? '0 : ex + CB'(1);
    ny       = ey;
    if (ex == LAST_X) ny = (ey == LAST_Y) ? '0 : ey + RB'(1);
    in_win   = !act_empty && (ex >= act_x1) && (ex <= act_xe) &&
               (ey >= act_y1) && (ey <= act_ye);
    win_user = (ex == act_x1) && (ey == act_y1);
    win_last = (ex == act_xe) && (ey == act_ye);
    push     = in_fire && in_win;
    pop      = pixel_out_TVALID && pixel_out_TREADY;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      shadow       <= '0;
      shadow_valid <= 1'b0;
      act_x1       <= '0;
      act_xe       <= '0;
      act_y1       <= '0;
      act_ye       <= '0;
      act_empty    <= 1'b1;
      x            <= '0;
      y            <= '0;
      sof_error    <= 1'b0;
    end else begin
      sof_error <= in_fire && resync;
      if (box_fire) begin
        shadow       <= crop_box_TDATA;
        shadow_valid <= 1'b1;
      end
      case (state)
        IDLE: begin
          x <= '0;
          y <= '0;
          if (shadow_valid) begin
            act_x1       <= sh_x1;
            act_y1       <= sh_y1;
            act_xe       <= sh_xe;
            act_ye       <= sh_ye;
            act_empty    <= sh_empty;
            shadow_valid <= box_fire;
            state        <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (in_fire) begin
            x <= nx;
            y <= ny;
            if (at_end) begin
              if (shadow_valid) begin
                act_x1       <= sh_x1;
                act_y1       <= sh_y1;
                act_xe       <= sh_xe;
                act_ye       <= sh_ye;
                act_empty    <= sh_empty;
                shadow_valid <= box_fire;
              end else begin
                state <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output register is the skid head; the spare slot only fills while stalled,
  // and a full spare is what deasserts pixel_in_TREADY.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pixel_out_TVALID <= 1'b0;
      pixel_out_TDATA  <= '0;
      pixel_out_TUSER  <= 1'b0;
      pixel_out_TLAST  <= 1'b0;
      spare_valid      <= 1'b0;
      spare_data       <= '0;
      spare_user       <= 1'b0;
      spare_last       <= 1'b0;
    end else if (pop) begin
      if (spare_valid) begin
        pixel_out_TDATA <= spare_data;
        pixel_out_TUSER <= spare_user;
        pixel_out_TLAST <= spare_last;
        spare_valid     <= 1'b0;
      end else begin
        pixel_out_TVALID <= push;
        pixel_out_TDATA  <= push ? pixel_in_TDATA : pixel_out_TDATA;
        pixel_out_TUSER  <= push && win_user;
        pixel_out_TLAST  <= push && win_last;
      end
    end else if (push) begin
      if (!pixel_out_TVALID) begin
        pixel_out_TVALID <= 1'b1;
        pixel_out_TDATA  <= pixel_in_TDATA;
        pixel_out_TUSER  <= win_user;
        pixel_out_TLAST  <= win_last;
      end else begin
        spare_valid <= 1'b1;
        spare_data  <= pixel_in_TDATA;
        spare_user  <= win_user;
        spare_last  <= win_last;
      end
    end
  end

endmodule

// File: tb/tb_crop_window_filter.sv
// Directed bench for crop_window_filter: a coordinate/window model predicts every
// output beat and sof_error pulse; literal checks pin the model per scenario.
module tb_crop_window_filter;

  localparam int PW = 12;
  localparam int NR = 40;
  localparam int NC = 40;
  localparam int RB = 10;
  localparam int CB = 10;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [PW-1:0]      pixel_in_TDATA;
  logic               pixel_in_TVALID;
  logic               pixel_in_TUSER;
  logic               pixel_in_TREADY;
  logic [2*(RB+CB)-1:0] crop_box_TDATA;
  logic               crop_box_TVALID;
  logic               crop_box_TREADY;
  logic [PW-1:0]      pixel_out_TDATA;
  logic               pixel_out_TVALID;
  logic               pixel_out_TUSER;
  logic               pixel_out_TLAST;
  logic               pixel_out_TREADY;
  logic               sof_error;

  crop_window_filter #(
    .PIXEL_BIT_WIDTH(PW), .IN_ROWS(NR), .IN_COLS(NC),
    .IMG_ROW_BITWIDTH(RB), .IMG_COL_BITWIDTH(CB)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .pixel_in_TDATA(pixel_in_TDATA), .pixel_in_TVALID(pixel_in_TVALID),
    .pixel_in_TUSER(pixel_in_TUSER), .pixel_in_TREADY(pixel_in_TREADY),
    .crop_box_TDATA(crop_box_TDATA), .crop_box_TVALID(crop_box_TVALID),
    .crop_box_TREADY(crop_box_TREADY),
    .pixel_out_TDATA(pixel_out_TDATA), .pixel_out_TVALID(pixel_out_TVALID),
    .pixel_out_TUSER(pixel_out_TUSER), .pixel_out_TLAST(pixel_out_TLAST),
    .pixel_out_TREADY(pixel_out_TREADY), .sof_error(sof_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] d;
    bit            u;
    bit            l;
    int            cyc;
  } beat_t;

  beat_t              exp_q[$];
  beat_t              cap_q[$];
  logic [2*(RB+CB)-1:0] box_q[$];

  int checks = 0;
  int errors = 0;
  int ncyc = 0;
  int stalls = 0;
  int sof_count = 0;
  bit lat_check = 1'b1;
  bit rand_rdy = 1'b0;

  // model state
  bit            m_in_frame = 1'b0;
  bit            sof_exp = 1'b0;
  int            mx, my, bx1, by1, bxe, bye;
  bit            bempty;
  bit            prev_stall = 1'b0;
  logic [PW-1:0] pdata;
  bit            puser, plast;

  always @(negedge clk) begin
    beat_t e;
    beat_t c;
    logic [2*(RB+CB)-1:0] b;
    int bw, bh;
    ncyc++;
    if (!reset_n) begin
      exp_q.delete();
      box_q.delete();
      m_in_frame = 1'b0;
      sof_exp    = 1'b0;
      prev_stall = 1'b0;
    end else begin
      checks++;
      if (sof_error !== sof_exp) begin
        errors++;
        $display("FAIL sof_error: got %0b expected %0b at cycle %0d", sof_error, sof_exp, ncyc);
      end
      if (sof_error) sof_count++;
      sof_exp = 1'b0;

      if (prev_stall) begin
        checks++;
        if (!pixel_out_TVALID || pixel_out_TDATA !== pdata ||
            pixel_out_TUSER !== puser || pixel_out_TLAST !== plast) begin
          errors++;
          $display("FAIL hold: got v=%0b d=%0d u=%0b l=%0b expected v=1 d=%0d u=%0b l=%0b",
                   pixel_out_TVALID, pixel_out_TDATA, pixel_out_TUSER, pixel_out_TLAST,
                   pdata, puser, plast);
        end
      end

      if (pixel_out_TVALID && pixel_out_TREADY) begin
        checks++;
        c.d = pixel_out_TDATA; c.u = pixel_out_TUSER; c.l = pixel_out_TLAST; c.cyc = ncyc;
        cap_q.push_back(c);
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_beat: got unexpected d=%0d expected no output", pixel_out_TDATA);
        end else begin
          e = exp_q.pop_front();
          if (c.d !== e.d || c.u !== e.u || c.l !== e.l ||
              (lat_check && c.cyc != e.cyc + 1)) begin
            errors++;
            $display("FAIL out_beat: got d=%0d u=%0b l=%0b cyc=%0d expected d=%0d u=%0b l=%0b cyc=%0d",
                     c.d, c.u, c.l, c.cyc, e.d, e.u, e.l, e.cyc + 1);
          end
        end
      end
      prev_stall = pixel_out_TVALID && !pixel_out_TREADY;
      pdata = pixel_out_TDATA; puser = pixel_out_TUSER; plast = pixel_out_TLAST;

      if (crop_box_TVALID && crop_box_TREADY) box_q.push_back(crop_box_TDATA);

      if (pixel_in_TVALID && pixel_in_TREADY) begin
        if (!m_in_frame) begin
          if (box_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL frame_start: got pixel accepted expected no box available");
          end else begin
            b   = box_q.pop_front();
            bx1 = int'(b[9:0]);   by1 = int'(b[19:10]);
            bw  = int'(b[29:20]); bh  = int'(b[39:30]);
            bxe = ((bx1 + bw < NC) ? bx1 + bw : NC) - 1;
            bye = ((by1 + bh < NR) ? by1 + bh : NR) - 1;
            bempty = (bw == 0) || (bh == 0) || (bx1 >= NC) || (by1 >= NR);
          end
          mx = 0; my = 0; m_in_frame = 1'b1;
        end else if (pixel_in_TUSER && (mx != 0 || my != 0)) begin
          mx = 0; my = 0; sof_exp = 1'b1;
        end
        if (!bempty && mx >= bx1 && mx <= bxe && my >= by1 && my <= bye) begin
          e.d = pixel_in_TDATA; e.u = (mx == bx1 && my == by1);
          e.l = (mx == bxe && my == bye); e.cyc = ncyc;
          exp_q.push_back(e);
        end
        if (mx == NC - 1 && my == NR - 1) m_in_frame = 1'b0;
        else if (mx == NC - 1) begin mx = 0; my++; end
        else mx++;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_rdy) pixel_out_TREADY = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send_box(input int x1, input int y1, input int w, input int h);
    bit r;
    int n = 0;
    crop_box_TDATA  = {10'(h), 10'(w), 10'(y1), 10'(x1)};
    crop_box_TVALID = 1'b1;
    do begin
      @(negedge clk); r = crop_box_TREADY;
      @(posedge clk); #1; n++;
    end while (!r && n < 200);
    crop_box_TVALID = 1'b0;
    if (!r) chk("box_timeout", 0, 1);
  endtask

  task automatic send_pixels(input int n, input int sof2);
    bit r;
    int w;
    for (int i = 0; i < n; i++) begin
      pixel_in_TDATA  = PW'(i);
      pixel_in_TUSER  = (i == 0) || (i == sof2);
      pixel_in_TVALID = 1'b1;
      w = 0;
      do begin
        @(negedge clk); r = pixel_in_TREADY;
        @(posedge clk); #1;
        if (!r) begin w++; stalls++; end
      end while (!r && w < 2000);
      if (!r) begin
        chk("pixel_timeout", 0, 1);
        break;
      end
    end
    pixel_in_TVALID = 1'b0;
    pixel_in_TUSER  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || pixel_out_TVALID) && n < 5000) begin
      @(negedge clk); n++;
    end
    @(posedge clk); #1;
    if (n >= 5000) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    reset_n = 1'b0;
    pixel_in_TDATA = '0; pixel_in_TVALID = 1'b0; pixel_in_TUSER = 1'b0;
    crop_box_TDATA = '0; crop_box_TVALID = 1'b0; pixel_out_TREADY = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(pixel_in_TREADY), 0);
    chk("rst_box_ready", int'(crop_box_TREADY), 1);
    chk("rst_out_valid", int'(pixel_out_TVALID), 0);
    chk("rst_out_user", int'(pixel_out_TUSER), 0);
    chk("rst_out_last", int'(pixel_out_TLAST), 0);
    chk("rst_sof", int'(sof_error), 0);
    reset_n = 1'b1;

    // basic crop of a ramp frame
    cap_q.delete();
    send_box(5, 3, 4, 2);
    send_pixels(NR * NC, -1);
    drain();
    chk("t1_count", cap_q.size(), 8);
    if (cap_q.size() == 8) begin
      chk("t1_first", int'(cap_q[0].d), 125);
      chk("t1_first_user", int'(cap_q[0].u), 1);
      chk("t1_row2", int'(cap_q[4].d), 165);
      chk("t1_last", int'(cap_q[7].d), 168);
      chk("t1_last_flag", int'(cap_q[7].l), 1);
    end

    // clipping at the bottom-right corner, then an empty box
    cap_q.delete();
    send_box(36, 38, 10, 10);
    send_pixels(NR * NC, -1);
    drain();
    chk("t2_count", cap_q.size(), 8);
    if (cap_q.size() == 8) begin
      chk("t2_first", int'(cap_q[0].d), 1556);
      chk("t2_last", int'(cap_q[7].d), 1599);
      chk("t2_last_flag", int'(cap_q[7].l), 1);
    end
    cap_q.delete();
    send_box(5, 5, 0, 5);
    send_pixels(NR * NC, -1);
    drain();
    repeat (2) @(posedge clk);
    #1;
    chk("t2_empty_count", cap_q.size(), 0);
    chk("t2_idle_ready", int'(pixel_in_TREADY), 0);

    // two preloaded boxes, back-to-back frames
    cap_q.delete();
    send_box(1, 1, 3, 3);
    send_box(0, 39, 40, 1);
    chk("t3_box_ready_low", int'(crop_box_TREADY), 0);
    stalls = 0;
    send_pixels(NR * NC, -1);
    send_pixels(NR * NC, -1);
    chk("t3_stalls", stalls, 0);
    drain();
    chk("t3_count", cap_q.size(), 49);
    if (cap_q.size() == 49) begin
      chk("t3_f1_first", int'(cap_q[0].d), 41);
      chk("t3_f2_first", int'(cap_q[9].d), 1560);
      chk("t3_f2_user", int'(cap_q[9].u), 1);
      chk("t3_f2_last", int'(cap_q[48].d), 1599);
    end

    // full frame under random back-pressure
    cap_q.delete();
    lat_check = 1'b0;
    rand_rdy  = 1'b1;
    send_box(0, 0, 40, 40);
    send_pixels(NR * NC, -1);
    drain();
    rand_rdy = 1'b0;
    pixel_out_TREADY = 1'b1;
    chk("t4_count", cap_q.size(), 1600);
    if (cap_q.size() == 1600) chk("t4_last", int'(cap_q[1599].d), 1599);
    lat_check = 1'b1;

    // resync at (10,7)
    cap_q.delete();
    sof_count = 0;
    send_box(2, 1, 3, 2);
    send_pixels(290 + NR * NC, 290);
    drain();
    chk("t5_sof_pulses", sof_count, 1);
    chk("t5_count", cap_q.size(), 12);
    if (cap_q.size() == 12) begin
      chk("t5_pre_first", int'(cap_q[0].d), 42);
      chk("t5_post_first", int'(cap_q[6].d), 332);
      chk("t5_post_user", int'(cap_q[6].u), 1);
      chk("t5_post_last", int'(cap_q[11].d), 374);
    end

    // reset with two pixels buffered
    lat_check = 1'b0;
    pixel_out_TREADY = 1'b0;
    send_box(0, 0, 40, 40);
    send_pixels(2, -1);
    chk("t6_full_ready", int'(pixel_in_TREADY), 0);
    chk("t6_head", int'(pixel_out_TDATA), 0);
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("t6_rst_valid", int'(pixel_out_TVALID), 0);
    chk("t6_rst_user", int'(pixel_out_TUSER), 0);
    chk("t6_rst_last", int'(pixel_out_TLAST), 0);
    chk("t6_rst_in_ready", int'(pixel_in_TREADY), 0);
    chk("t6_rst_box_ready", int'(crop_box_TREADY), 1);
    reset_n = 1'b1;
    pixel_out_TREADY = 1'b1;
    lat_check = 1'b1;
    cap_q.delete();
    send_box(5, 3, 4, 2);
    send_pixels(NR * NC, -1);
    drain();
    chk("t6_count", cap_q.size(), 8);
    if (cap_q.size() == 8) chk("t6_first", int'(cap_q[0].d), 125);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
